// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR file.
package csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;
    localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH = 12'hB80;

    // Interrupt cause codes
    localparam logic [3:0] CAUSE_M_EXT_IRQ   = 4'd11;
    localparam logic [3:0] CAUSE_M_TIMER_IRQ = 4'd7;

    // Bit positions inside mstatus / mie / mip
    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MIX_MTI_BIT      = 7;
    localparam int unsigned MIX_MEI_BIT      = 11;

    // CSR access operation
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

endpackage

// File: rtl/csr_counter.sv
// 64-bit free-running cycle counter with independent half loads.
module csr_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic [31:0] load_data,
    output logic [63:0] count
);

    // Increment every cycle; a loaded half replaces its increment for that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            if (load_lo) begin
                count[31:0] <= load_data;
            end else if (load_hi) begin
                count[63:32] <= load_data;
                count[31:0]  <= count[31:0] + 32'd1;
            end else begin
                count <= count + 64'd1;
            end
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: CSR access, trap entry, MRET return, cycle counter.
// XLEN is assumed to be at least 32.
module csr_file
    import csr_pkg::*;
#(
    parameter int unsigned        XLEN        = 32,
    parameter logic [XLEN-1:0]    RESET_MTVEC = '0,
    parameter int                 HAS_MCYCLE  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic            csr_rd,
    input  logic            csr_wr,
    output logic [XLEN-1:0] rdata,
    output logic            illegal,
    input  logic [XLEN-1:0] pc,
    input  logic            exc,
    input  logic [3:0]      exc_cause,
    input  logic            ext_irq,
    input  logic            timer_irq,
    input  logic            is_mret,
    output logic            trap_taken,
    output logic [XLEN-1:0] trap_vector,
    output logic            epc_taken,
    output logic [XLEN-1:0] epc
);

    localparam logic [XLEN-1:0] ALIGN4_MASK = ~(XLEN'(3));
    localparam logic [XLEN-1:0] MTVEC_MASK  = ~(XLEN'(2));

    csr_op_e         op;
    logic            mstatus_mie, mstatus_mpie;
    logic            mie_mtie, mie_meie;
    logic            mip_mtip, mip_meip;
    logic [XLEN-1:0] mtvec, mepc, mcause;
    logic [63:0]     cycle;
    logic [XLEN-1:0] csr_old, csr_new;
    logic            addr_known, wr_fire;
    logic            irq_ext, irq_tmr, irq_pend;
    logic [3:0]      trap_cause;
    logic [XLEN-1:0] mtvec_base;

    assign op = csr_op_e'(csr_op);

    // Current value of the addressed CSR and whether the address exists.
    always_comb begin
        csr_old    = '0;
        addr_known = 1'b1;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_old[MSTATUS_MIE_BIT]  = mstatus_mie;
                csr_old[MSTATUS_MPIE_BIT] = mstatus_mpie;
            end
            CSR_MIE: begin
                csr_old[MIX_MTI_BIT] = mie_mtie;
                csr_old[MIX_MEI_BIT] = mie_meie;
            end
            CSR_MIP: begin
                csr_old[MIX_MTI_BIT] = mip_mtip;
                csr_old[MIX_MEI_BIT] = mip_meip;
            end
            CSR_MTVEC:   csr_old = mtvec;
            CSR_MEPC:    csr_old = mepc;
            CSR_MCAUSE:  csr_old = mcause;
            CSR_MCYCLE:  csr_old = XLEN'(cycle[31:0]);
            CSR_MCYCLEH: csr_old = XLEN'(cycle[63:32]);
            default:     addr_known = 1'b0;
        endcase
    end

    // Read-modify-write value for the selected operation.
    always_comb begin
        csr_new = csr_old;
        case (op)
            CSR_OP_RW: csr_new = csr_wdata;
            CSR_OP_RS: csr_new = csr_old | csr_wdata;
            CSR_OP_RC: csr_new = csr_old & ~csr_wdata;
            default:   csr_new = csr_old;
        endcase
    end

    // Interrupt arbitration and trap target selection.
    always_comb begin
        irq_ext    = mie_meie & mip_meip;
        irq_tmr    = mie_mtie & mip_mtip;
        irq_pend   = mstatus_mie & (irq_ext | irq_tmr);
        trap_taken = !rst && (exc || irq_pend);
        if (exc)          trap_cause = exc_cause;
        else if (irq_ext) trap_cause = CAUSE_M_EXT_IRQ;
        else              trap_cause = CAUSE_M_TIMER_IRQ;
        mtvec_base = mtvec & ALIGN4_MASK;
        if (rst)
            trap_vector = RESET_MTVEC;
        else if (mtvec[0] && !exc)
            trap_vector = mtvec_base + {{(XLEN-6){1'b0}}, trap_cause, 2'b00};
        else
            trap_vector = mtvec_base;
    end

    assign wr_fire   = csr_wr && (op != CSR_OP_NONE) && addr_known &&
                       (csr_addr != CSR_MIP) && !trap_taken;
    assign illegal   = !rst && (((csr_rd || csr_wr) && !addr_known) ||
                                (csr_wr && csr_addr == CSR_MIP));
    assign rdata     = (!rst && csr_rd && addr_known) ? csr_old : '0;
    assign epc_taken = is_mret;
    assign epc       = mepc;

    // Architectural CSR state: trap beats MRET beats a CSR write to mstatus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_mtie     <= 1'b0;
            mie_meie     <= 1'b0;
            mip_mtip     <= 1'b0;
            mip_meip     <= 1'b0;
            mtvec        <= RESET_MTVEC & MTVEC_MASK;
            mepc         <= '0;
            mcause       <= '0;
        end else begin
            mip_meip <= ext_irq;
            mip_mtip <= timer_irq;
            if (trap_taken) begin
                mepc         <= pc & ALIGN4_MASK;
                mcause       <= {!exc, {(XLEN-5){1'b0}}, trap_cause};
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else begin
                if (is_mret) begin
                    mstatus_mie  <= mstatus_mpie;
                    mstatus_mpie <= 1'b1;
                end
                if (wr_fire) begin
                    case (csr_addr)
                        CSR_MSTATUS: if (!is_mret) begin
                            mstatus_mie  <= csr_new[MSTATUS_MIE_BIT];
                            mstatus_mpie <= csr_new[MSTATUS_MPIE_BIT];
                        end
                        CSR_MIE: begin
                            mie_mtie <= csr_new[MIX_MTI_BIT];
                            mie_meie <= csr_new[MIX_MEI_BIT];
                        end
                        CSR_MTVEC:  mtvec  <= csr_new & MTVEC_MASK;
                        CSR_MEPC:   mepc   <= csr_new & ALIGN4_MASK;
                        CSR_MCAUSE: mcause <= csr_new;
                        default: ;
                    endcase
                end
            end
        end
    end

    csr_counter u_counter (
        .clk       (clk),
        .rst       (rst),
        .en        (HAS_MCYCLE != 0),
        .load_lo   (wr_fire && csr_addr == CSR_MCYCLE  && HAS_MCYCLE != 0),
        .load_hi   (wr_fire && csr_addr == CSR_MCYCLEH && HAS_MCYCLE != 0),
        .load_data (csr_new[31:0]),
        .count     (cycle)
    );

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width of all CSRs except the 64-bit counter.
REQ-002 SHALL have parameter RESET_MTVEC, default 32'h0000_0000, meaning mtvec value after reset.
REQ-003 SHALL have parameter HAS_MCYCLE, default 1, meaning mcycle/mcycleh implemented (0: both read 0, writes ignored).
REQ-004 SHALL have ports: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-005 SHALL have ports: csr_addr in 12, CSR address; csr_op in 2, 01=RW 10=RS 11=RC 00=none; csr_wdata in XLEN, rs1/immediate operand.
REQ-006 SHALL have ports: csr_rd in 1, read strobe; csr_wr in 1, write strobe; rdata out XLEN, old CSR value; illegal out 1, unknown address accessed.
REQ-007 SHALL have ports: pc in XLEN, PC of current instruction; exc in 1, synchronous exception request; exc_cause in 4, exception code.
REQ-008 SHALL have ports: ext_irq in 1, external interrupt level; timer_irq in 1, timer interrupt level; is_mret in 1, MRET executing.
REQ-009 SHALL have ports: trap_taken out 1, redirect to trap; trap_vector out XLEN, handler PC; epc_taken out 1, redirect for MRET; epc out XLEN, mepc value.

Function
REQ-010 SHALL implement mstatus 0x300 (MIE bit3, MPIE bit7, others read 0), mie 0x304 (MTIE bit7, MEIE bit11), mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00, mcycleh 0xB80.
REQ-011 SHALL read combinationally: rdata = addressed CSR when csr_rd=1 and address known, else 0.
REQ-012 SHALL assert illegal combinationally when (csr_rd|csr_wr)=1 and address unknown, or on write to mip; such writes are dropped.
REQ-013 SHALL write on the rising edge when csr_wr=1: RW new=wdata, RS new=old|wdata, RC new=old&~wdata, op 00 no write.
REQ-014 SHALL mask writes to implemented bits only; mepc[1:0] and mtvec[1] always 0.
REQ-015 SHALL register ext_irq/timer_irq into mip.MEIP(bit11)/MTIP(bit7) each cycle (one-cycle latency), software read-only.
REQ-016 SHALL compute irq_pend = mstatus.MIE & |(mie & mip).
REQ-017 SHALL assert trap_taken combinationally when exc=1 or irq_pend=1; priority exc > external (cause 11) > timer (cause 7).
REQ-018 SHALL set trap_vector = mtvec base for exceptions or mtvec[0]=0; base + 4*cause for interrupts when mtvec[0]=1 (vectored).
REQ-019 SHALL on trap edge: mepc<=pc, mcause<={interrupt bit31, cause}, MPIE<=MIE, MIE<=0.
REQ-020 SHALL assert epc_taken=is_mret and drive epc=mepc every cycle; on MRET edge MIE<=MPIE, MPIE<=1.
REQ-021 SHALL give trap priority over MRET and CSR write in the same cycle; the lower-priority update is dropped entirely.
REQ-022 SHALL give MRET priority over a CSR write to mstatus in the same cycle; writes to other CSRs proceed.
REQ-023 SHALL increment 64-bit mcycle every cycle with carry into mcycleh; wrap 2^64-1 -> 0.
REQ-024 SHALL let a CSR write to mcycle/mcycleh replace that half for that edge instead of incrementing; the other half is unaffected.

Reset
REQ-025 SHALL on rst=1 asynchronously clear mstatus, mie, mip, mepc, mcause, mcycle, and set mtvec=RESET_MTVEC.
REQ-026 SHALL hold outputs during reset: rdata=0, illegal=0, trap_taken=0, epc_taken=is_mret, epc=0, trap_vector=RESET_MTVEC.
REQ-027 SHALL discard any trap, MRET or write in progress when reset asserts mid-cycle.

Structure
REQ-028 SHALL place CSR address constants, cause codes, csr_op enum and bit-position constants in package csr_pkg.
REQ-029 SHALL implement the 64-bit counter as sub-module csr_counter (increment, per-half load, enable).

Verification
REQ-030 SHALL cover: RW mtvec=0x100, RS mie with 0x800, RC mie with 0x800 -> rdata returns 0x0, 0x0, 0x800 old values; mie ends 0.
REQ-031 SHALL cover: MIE=1, MEIE=1, ext_irq pulse, pc=0x40, mtvec=0x101 -> trap_vector=0x12C, mcause=0x8000000B, mepc=0x40, MIE=0, MPIE=1.
REQ-032 SHALL cover: exc=1 cause 2 together with pending timer irq -> mcause=2, trap_vector=mtvec base; then is_mret -> epc=mepc, MIE restored.
REQ-033 SHALL cover: write mcycle=0xFFFFFFFF, mcycleh=0 then idle one cycle -> mcycle=0, mcycleh=1; csr_wr to 0x7C0 -> illegal=1, no state change.
REQ-034 SHALL cover: rst asserted between clock edges during trap cycle -> all CSRs at reset values immediately, mtvec=RESET_MTVEC.
